prog_loader: RTL and testbench

- Writer-side counterpart to the core's instruction fetch: receives a byte stream over a valid/ready handshake and packs byte pairs into 9-bit machine-code words.
- Writes each word into the writable instruction memory, then launches the core with a one-cycle start pulse.
- Waits for the core's done, then returns to idle.
- Sits between the host/test interface and the instruction memory write port / core start input.

---
 rtl/prog_loader.sv | 123 ++++++++++++
 tb/tb_prog_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: packs byte pairs into 9-bit words, writes them
// into instruction memory, launches the core and waits for its done flag.
module prog_loader #(
    parameter int D         = 12,
    parameter int W         = 9,
    parameter int MAX_WORDS = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_req,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         im_wr_en,
    output logic [D-1:0] im_addr,
    output logic [W-1:0] im_wr_data,
    output logic         start,
    input  logic         cpu_done,
    output logic         busy,
    output logic         run_done,
    output logic         err,
    output logic [D:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_LAUNCH,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [D:0] MAX_W = (D+1)'(MAX_WORDS);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] lo_reg;
    logic       hi_bad;
    logic       full;
    logic       lo_take;
    logic       write_ok;
    logic       load_start;

    assign hi_bad     = in_data[7:1] != 7'd0;
    assign full       = words_loaded == MAX_W;
    assign lo_take    = (state == S_LO) && in_valid;
    assign write_ok   = (state == S_HI) && in_valid && !hi_bad && !full;
    assign load_start = load_req && ((state == S_IDLE) || (state == S_ERR));

    assign start = state == S_LAUNCH;
    assign err   = state == S_ERR;
    assign busy  = (state != S_IDLE) && (state != S_ERR);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (load_req)
                    state_nxt = S_LO;
            end
            S_LO: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = in_last ? S_ERR : S_HI;
            end
            S_HI: begin
                in_ready = 1'b1;
                // Error checks outrank in_last, so a bad final byte never launches.
                if (in_valid) begin
                    if (hi_bad || full)
                        state_nxt = S_ERR;
                    else if (in_last)
                        state_nxt = S_LAUNCH;
                    else
                        state_nxt = S_LO;
                end
            end
            S_LAUNCH: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (cpu_done)
                    state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (load_req)
                    state_nxt = S_LO;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            lo_reg       <= 8'd0;
            im_wr_en     <= 1'b0;
            im_addr      <= '0;
            im_wr_data   <= '0;
            run_done     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state    <= state_nxt;
            im_wr_en <= write_ok;
            run_done <= (state == S_RUN) && cpu_done;
            if (lo_take)
                lo_reg <= in_data;
            if (write_ok) begin
                im_addr      <= words_loaded[D-1:0];
                im_wr_data   <= W'({in_data[0], lo_reg});
                words_loaded <= words_loaded + 1'b1;
            end
            if (load_start)
                words_loaded <= '0;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, backpressure, errors, overflow,
// run handshake and mid-load reset.
module tb_prog_loader;

    localparam int D  = 12;
    localparam int W  = 9;
    localparam int MW = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_req;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_last;
    logic         in_ready;
    logic         im_wr_en;
    logic [D-1:0] im_addr;
    logic [W-1:0] im_wr_data;
    logic         start;
    logic         cpu_done;
    logic         busy;
    logic         run_done;
    logic         err;
    logic [D:0]   words_loaded;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    int wr_n;
    int acc_n;
    int starts;
    int wr_addr [32];
    int wr_data [32];
    int wr_cyc  [32];
    int acc_cyc [32];

    prog_loader #(.D(D), .W(W), .MAX_WORDS(MW)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_req     (load_req),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .im_wr_en     (im_wr_en),
        .im_addr      (im_addr),
        .im_wr_data   (im_wr_data),
        .start        (start),
        .cpu_done     (cpu_done),
        .busy         (busy),
        .run_done     (run_done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log sampled mid-cycle, between input changes and clock edges
    always @(negedge clk) begin
        if (in_valid && in_ready && acc_n < 32) begin
            acc_cyc[acc_n] = cyc;
            acc_n = acc_n + 1;
        end
        if (im_wr_en && wr_n < 32) begin
            wr_addr[wr_n] = int'(im_addr);
            wr_data[wr_n] = int'(im_wr_data);
            wr_cyc[wr_n]  = cyc;
            wr_n = wr_n + 1;
        end
        if (start)
            starts = starts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        wr_n   = 0;
        acc_n  = 0;
        starts = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last,
                             input int gap);
        int bound;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            step();
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        bound    = 0;
        while (!in_ready && bound < 50) begin
            step();
            bound++;
        end
        if (bound >= 50)
            chk("rdy_timeout", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_load();
        load_req = 1'b1;
        step();
        load_req = 1'b0;
    endtask

    // Checks write k: address, data and that it lands 1 cycle after its HI byte
    task automatic chk_wr(input int k, input int a, input int d);
        chk($sformatf("wr%0d_addr", k), 32'(wr_addr[k]), 32'(a));
        chk($sformatf("wr%0d_data", k), 32'(wr_data[k]), 32'(d));
        chk($sformatf("wr%0d_lat", k), 32'(wr_cyc[k]),
            32'(acc_cyc[2*k+1] + 1));
    endtask

    task automatic finish_run();
        int bound;
        cpu_done = 1'b1;
        step();
        chk("run_done_pulse", 32'(run_done), 32'd1);
        chk("run_idle_busy", 32'(busy), 32'd0);
        cpu_done = 1'b0;
        step();
        chk("run_done_clr", 32'(run_done), 32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        load_req = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        cpu_done = 1'b0;
        clear_log();
        step();
        step();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_outs", {26'd0, im_wr_en, start, busy, run_done, err,
            1'b0}, 32'd0);
        chk("rst_addr", 32'(im_addr), 32'd0);
        chk("rst_data", 32'(im_wr_data), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        reset = 1'b0;

        // Bytes offered in IDLE must be ignored
        in_valid = 1'b1;
        in_data  = 8'h77;
        repeat (3) step();
        in_valid = 1'b0;
        chk("idle_no_accept", 32'(acc_n), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd0);

        // Basic 3-word load
        do_load();
        chk("lo_busy", 32'(busy), 32'd1);
        clear_log();
        send_byte(8'h5A, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h33, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'hFF, 1'b0, 0);
        send_byte(8'h01, 1'b1, 0);
        chk("launch_start", 32'(start), 32'd1);
        chk("launch_wr_en", 32'(im_wr_en), 32'd1);
        chk("launch_words", 32'(words_loaded), 32'd3);
        chk("launch_ready", 32'(in_ready), 32'd0);
        step();
        chk("start_one_cycle", 32'(start), 32'd0);
        chk("wr_count", 32'(wr_n), 32'd3);
        chk_wr(0, 0, 'h15A);
        chk_wr(1, 1, 'h033);
        chk_wr(2, 2, 'h1FF);

        // Hold in RUN with junk bytes offered
        in_valid = 1'b1;
        in_data  = 8'h00;
        for (int i = 0; i < 20; i++) begin
            chk("run_busy", {30'd0, busy, in_ready}, 32'b10);
            step();
        end
        in_valid = 1'b0;
        chk("run_no_accept", 32'(acc_n), 32'd6);
        chk("run_no_write", 32'(wr_n), 32'd3);
        chk("run_starts", 32'(starts), 32'd1);
        finish_run();
        chk("words_hold", 32'(words_loaded), 32'd3);

        // Same load with random gaps
        do_load();
        clear_log();
        send_byte(8'h5A, 1'b0, $urandom_range(0, 3));
        send_byte(8'h01, 1'b0, $urandom_range(0, 3));
        send_byte(8'h33, 1'b0, $urandom_range(0, 3));
        send_byte(8'h00, 1'b0, $urandom_range(0, 3));
        send_byte(8'hFF, 1'b0, $urandom_range(0, 3));
        send_byte(8'h01, 1'b1, $urandom_range(0, 3));
        step();
        chk("gap_wr_count", 32'(wr_n), 32'd3);
        chk_wr(0, 0, 'h15A);
        chk_wr(1, 1, 'h033);
        chk_wr(2, 2, 'h1FF);
        chk("gap_starts", 32'(starts), 32'd1);
        finish_run();

        // Odd byte count
        do_load();
        clear_log();
        send_byte(8'h11, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h22, 1'b1, 0);
        step();
        chk("odd_err", 32'(err), 32'd1);
        chk("odd_busy", 32'(busy), 32'd0);
        chk("odd_wr_count", 32'(wr_n), 32'd1);
        chk("odd_starts", 32'(starts), 32'd0);
        chk("odd_words", 32'(words_loaded), 32'd1);

        // Bad HI byte, restarted from ERR
        do_load();
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_words_clr", 32'(words_loaded), 32'd0);
        clear_log();
        send_byte(8'h44, 1'b0, 0);
        send_byte(8'h02, 1'b0, 0);
        step();
        chk("hi_err", 32'(err), 32'd1);
        chk("hi_no_write", 32'(wr_n), 32'd0);

        // Fresh load after ERR
        do_load();
        clear_log();
        send_byte(8'hAA, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'hBB, 1'b0, 0);
        send_byte(8'h01, 1'b1, 0);
        step();
        chk("fresh_wr_count", 32'(wr_n), 32'd2);
        chk_wr(0, 0, 'h0AA);
        chk_wr(1, 1, 'h1BB);
        chk("fresh_starts", 32'(starts), 32'd1);
        finish_run();

        // Overflow: fifth word with MAX_WORDS of four
        do_load();
        clear_log();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(i * 3 + 1), 1'b0, 0);
            send_byte(8'(i & 1), i == 4, 0);
        end
        step();
        chk("ovf_err", 32'(err), 32'd1);
        chk("ovf_wr_count", 32'(wr_n), 32'd4);
        chk("ovf_starts", 32'(starts), 32'd0);
        chk("ovf_words", 32'(words_loaded), 32'd4);
        chk_wr(0, 0, 'h001);
        chk_wr(1, 1, 'h104);
        chk_wr(2, 2, 'h007);
        chk_wr(3, 3, 'h10A);

        // Reset mid-load
        do_load();
        clear_log();
        send_byte(8'h10, 1'b0, 0);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h20, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        send_byte(8'h30, 1'b0, 0);
        chk("mid_words", 32'(words_loaded), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_outs", {25'd0, in_ready, im_wr_en, start, busy,
            run_done, err, 1'b0}, 32'd0);
        chk("mid_rst_words", 32'(words_loaded), 32'd0);
        chk("mid_rst_addr", 32'(im_addr), 32'd0);
        step();
        do_load();
        clear_log();
        send_byte(8'h66, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        step();
        chk("post_rst_wr_count", 32'(wr_n), 32'd1);
        chk_wr(0, 0, 'h166);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
